// File: rtl/ime_mv_buf_ctrl.sv
// Motion-vector buffer between IME and FME: collects one CTU of clipped MVs into a
// single-port RAM, then streams them out in index order through a 2-entry FIFO.
module ime_mv_buf_ctrl #(
    parameter int unsigned NUM_MV = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        mv_vld_i,
    output logic        mv_rdy_o,
    input  logic [5:0]  mv_idx_i,
    input  logic [9:0]  mv_x_i,
    input  logic [8:0]  mv_y_i,
    output logic        wr_done_o,
    output logic        out_vld_o,
    input  logic        out_rdy_i,
    output logic [5:0]  out_idx_o,
    output logic [12:0] out_dat_o,
    output logic        rd_done_o,
    output logic [5:0]  ram_adr_o,
    output logic        ram_wr_ena_o,
    output logic [12:0] ram_wr_dat_o,
    output logic        ram_rd_ena_o,
    input  logic [12:0] ram_rd_dat_i,
    output logic        busy_o
);

    typedef enum logic [1:0] {StIdle, StWr, StRd} state_e;

    localparam logic [6:0] NumMv   = 7'(NUM_MV);
    localparam logic [6:0] LastCnt = 7'(NUM_MV - 1);

    state_e            state_q, state_d;
    logic [6:0]        wr_cnt_q, wr_cnt_d;
    logic [6:0]        rd_cnt_q, rd_cnt_d;
    logic [6:0]        out_cnt_q, out_cnt_d;
    logic              inflight_q, inflight_d;
    logic [5:0]        inflight_idx_q, inflight_idx_d;
    logic [1:0][12:0]  fifo_dat_q, fifo_dat_d;
    logic [1:0][5:0]   fifo_idx_q, fifo_idx_d;
    logic              fifo_wp_q, fifo_wp_d;
    logic              fifo_rp_q, fifo_rp_d;
    logic [1:0]        fifo_cnt_q, fifo_cnt_d;

    logic              accept;
    logic              pop;
    logic              rd_issue;
    logic [2:0]        level;
    logic [6:0]        x_clip;
    logic [5:0]        y_clip;

    // Saturate to the 7-bit / 6-bit signed ranges stored in the RAM word.
    always_comb begin
        x_clip = mv_x_i[6:0];
        if ($signed(mv_x_i) > 10'sd63) begin
            x_clip = 7'h3F;
        end else if ($signed(mv_x_i) < -10'sd64) begin
            x_clip = 7'h40;
        end
        y_clip = mv_y_i[5:0];
        if ($signed(mv_y_i) > 9'sd31) begin
            y_clip = 6'h1F;
        end else if ($signed(mv_y_i) < -9'sd32) begin
            y_clip = 6'h20;
        end
    end

    always_comb begin
        accept   = !rst && (state_q == StWr) && mv_vld_i && !start_i;
        pop      = !rst && (state_q == StRd) && (fifo_cnt_q != 2'd0) && out_rdy_i && !start_i;
        // Entries that will be held next cycle if nothing new is issued now.
        level    = 3'(fifo_cnt_q) + 3'(inflight_q) - 3'(pop);
        rd_issue = !rst && (state_q == StRd) && !start_i && (rd_cnt_q < NumMv) && (level < 3'd2);

        mv_rdy_o     = !rst && (state_q == StWr);
        busy_o       = !rst && (state_q != StIdle);
        wr_done_o    = accept && (wr_cnt_q == LastCnt);
        out_vld_o    = !rst && (state_q == StRd) && (fifo_cnt_q != 2'd0);
        out_dat_o    = out_vld_o ? fifo_dat_q[fifo_rp_q] : 13'h0;
        out_idx_o    = out_vld_o ? fifo_idx_q[fifo_rp_q] : 6'h0;
        rd_done_o    = pop && (out_cnt_q == LastCnt);
        ram_wr_ena_o = !accept;
        ram_rd_ena_o = !rd_issue;
        ram_wr_dat_o = accept ? {y_clip, x_clip} : 13'h0;
        ram_adr_o    = 6'h0;
        if (accept) begin
            ram_adr_o = mv_idx_i;
        end else if (rd_issue) begin
            ram_adr_o = rd_cnt_q[5:0];
        end
    end

    always_comb begin
        state_d        = state_q;
        wr_cnt_d       = wr_cnt_q;
        rd_cnt_d       = rd_cnt_q;
        out_cnt_d      = out_cnt_q;
        inflight_d     = rd_issue;
        inflight_idx_d = inflight_idx_q;
        fifo_dat_d     = fifo_dat_q;
        fifo_idx_d     = fifo_idx_q;
        fifo_wp_d      = fifo_wp_q;
        fifo_rp_d      = fifo_rp_q;
        fifo_cnt_d     = fifo_cnt_q;

        if (start_i) begin
            state_d    = StWr;
            wr_cnt_d   = 7'd0;
            rd_cnt_d   = 7'd0;
            out_cnt_d  = 7'd0;
            inflight_d = 1'b0;
            fifo_wp_d  = 1'b0;
            fifo_rp_d  = 1'b0;
            fifo_cnt_d = 2'd0;
        end else begin
            unique case (state_q)
                StWr: begin
                    if (accept) begin
                        wr_cnt_d = wr_cnt_q + 7'd1;
                        if (wr_cnt_q == LastCnt) begin
                            state_d   = StRd;
                            rd_cnt_d  = 7'd0;
                            out_cnt_d = 7'd0;
                        end
                    end
                end
                StRd: begin
                    if (rd_issue) begin
                        rd_cnt_d       = rd_cnt_q + 7'd1;
                        inflight_idx_d = rd_cnt_q[5:0];
                    end
                    // RAM data for last cycle's read is valid now.
                    if (inflight_q) begin
                        fifo_dat_d[fifo_wp_q] = ram_rd_dat_i;
                        fifo_idx_d[fifo_wp_q] = inflight_idx_q;
                        fifo_wp_d             = !fifo_wp_q;
                    end
                    if (pop) begin
                        fifo_rp_d = !fifo_rp_q;
                        out_cnt_d = out_cnt_q + 7'd1;
                        if (out_cnt_q == LastCnt) begin
                            state_d = StIdle;
                        end
                    end
                    fifo_cnt_d = fifo_cnt_q + 2'(inflight_q) - 2'(pop);
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            wr_cnt_q       <= 7'd0;
            rd_cnt_q       <= 7'd0;
            out_cnt_q      <= 7'd0;
            inflight_q     <= 1'b0;
            inflight_idx_q <= 6'd0;
            fifo_dat_q     <= '0;
            fifo_idx_q     <= '0;
            fifo_wp_q      <= 1'b0;
            fifo_rp_q      <= 1'b0;
            fifo_cnt_q     <= 2'd0;
        end else begin
            state_q        <= state_d;
            wr_cnt_q       <= wr_cnt_d;
            rd_cnt_q       <= rd_cnt_d;
            out_cnt_q      <= out_cnt_d;
            inflight_q     <= inflight_d;
            inflight_idx_q <= inflight_idx_d;
            fifo_dat_q     <= fifo_dat_d;
            fifo_idx_q     <= fifo_idx_d;
            fifo_wp_q      <= fifo_wp_d;
            fifo_rp_q      <= fifo_rp_d;
            fifo_cnt_q     <= fifo_cnt_d;
        end
    end

endmodule

// File: tb/tb_ime_mv_buf_ctrl.sv
// Bench for ime_mv_buf_ctrl: randomized CTUs against a counting/queue reference model,
// plus a NUM_MV=1 instance driven with hand-computed expectations.
module tb_ime_mv_buf_ctrl;

    localparam int N = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start_i, mv_vld_i, out_rdy_i;
    logic [5:0]  mv_idx_i;
    logic [9:0]  mv_x_i;
    logic [8:0]  mv_y_i;
    logic        mv_rdy_o, wr_done_o, out_vld_o, rd_done_o, ram_wr_ena_o, ram_rd_ena_o, busy_o;
    logic [5:0]  out_idx_o, ram_adr_o;
    logic [12:0] out_dat_o, ram_wr_dat_o, ram_rd_dat_i;

    logic        s_start, s_vld, s_rdy, s_wr_done, s_out_vld, s_out_rdy, s_rd_done;
    logic        s_wr_ena, s_rd_ena, s_busy;
    logic [5:0]  s_idx, s_out_idx, s_adr;
    logic [9:0]  s_x;
    logic [8:0]  s_y;
    logic [12:0] s_out_dat, s_wr_dat, s_rd_dat;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    ime_mv_buf_ctrl #(.NUM_MV(N)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .mv_vld_i(mv_vld_i), .mv_rdy_o(mv_rdy_o),
        .mv_idx_i(mv_idx_i), .mv_x_i(mv_x_i), .mv_y_i(mv_y_i), .wr_done_o(wr_done_o),
        .out_vld_o(out_vld_o), .out_rdy_i(out_rdy_i), .out_idx_o(out_idx_o),
        .out_dat_o(out_dat_o), .rd_done_o(rd_done_o), .ram_adr_o(ram_adr_o),
        .ram_wr_ena_o(ram_wr_ena_o), .ram_wr_dat_o(ram_wr_dat_o), .ram_rd_ena_o(ram_rd_ena_o),
        .ram_rd_dat_i(ram_rd_dat_i), .busy_o(busy_o)
    );

    ime_mv_buf_ctrl #(.NUM_MV(1)) dut1 (
        .clk(clk), .rst(rst), .start_i(s_start), .mv_vld_i(s_vld), .mv_rdy_o(s_rdy),
        .mv_idx_i(s_idx), .mv_x_i(s_x), .mv_y_i(s_y), .wr_done_o(s_wr_done),
        .out_vld_o(s_out_vld), .out_rdy_i(s_out_rdy), .out_idx_o(s_out_idx),
        .out_dat_o(s_out_dat), .rd_done_o(s_rd_done), .ram_adr_o(s_adr),
        .ram_wr_ena_o(s_wr_ena), .ram_wr_dat_o(s_wr_dat), .ram_rd_ena_o(s_rd_ena),
        .ram_rd_dat_i(s_rd_dat), .busy_o(s_busy)
    );

    // Single-port synchronous-read RAMs, one per instance.
    logic [12:0] mem  [64];
    logic [12:0] mem1 [64];
    always @(posedge clk) begin
        if (!ram_wr_ena_o) mem[ram_adr_o] <= ram_wr_dat_o;
        if (!ram_rd_ena_o) ram_rd_dat_i <= mem[ram_adr_o];
        if (!s_wr_ena) mem1[s_adr] <= s_wr_dat;
        if (!s_rd_ena) s_rd_dat <= mem1[s_adr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [12:0] pack(input int x, input int y);
        int cx, cy;
        cx = (x > 63) ? 63 : ((x < -64) ? -64 : x);
        cy = (y > 31) ? 31 : ((y < -32) ? -32 : y);
        return {cy[5:0], cx[6:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: phase 0 idle, 1 collecting, 2 streaming. q holds issue cycles of
    // reads not yet handed out; a read's word is visible two cycles after issue.
    int          phase = 0, wr_n = 0, issued = 0, popped = 0;
    int          q[$];
    logic [12:0] gold [64];
    bit          after_rst = 0;

    initial begin
        bit m_acc, e_vld, m_pop, e_iss;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                phase = 0; wr_n = 0; issued = 0; popped = 0;
                q.delete();
                after_rst = 1;
            end else begin
                m_acc = (phase == 1) && mv_vld_i && !start_i;
                e_vld = (phase == 2) && (q.size() > 0) && (q[0] <= cyc - 2);
                m_pop = e_vld && out_rdy_i && !start_i;
                e_iss = (phase == 2) && !start_i && (issued < N) &&
                        ((q.size() - int'(m_pop)) < 2);
                chk("mv_rdy", mv_rdy_o, phase == 1);
                chk("busy", busy_o, phase != 0);
                chk("wr_done", wr_done_o, m_acc && (wr_n == N - 1));
                chk("ram_wr_ena", ram_wr_ena_o, !m_acc);
                if (m_acc) begin
                    chk("wr_adr", ram_adr_o, mv_idx_i);
                    chk("wr_dat", ram_wr_dat_o, pack($signed(mv_x_i), $signed(mv_y_i)));
                end
                chk("ram_rd_ena", ram_rd_ena_o, !e_iss);
                if (e_iss) chk("rd_adr", ram_adr_o, issued);
                chk("out_vld", out_vld_o, e_vld);
                if (e_vld) begin
                    chk("out_idx", out_idx_o, popped);
                    chk("out_dat", out_dat_o, gold[popped]);
                end
                chk("rd_done", rd_done_o, m_pop && (popped == N - 1));
                if (after_rst) begin
                    chk("rst_adr", ram_adr_o, 0);
                    chk("rst_wr_dat", ram_wr_dat_o, 0);
                    chk("rst_out_dat", out_dat_o, 0);
                    chk("rst_out_idx", out_idx_o, 0);
                end
                after_rst = 0;
                if (start_i) begin
                    phase = 1; wr_n = 0; issued = 0; popped = 0;
                    q.delete();
                end else if (m_acc) begin
                    gold[mv_idx_i] = pack($signed(mv_x_i), $signed(mv_y_i));
                    wr_n++;
                    if (wr_n == N) phase = 2;
                end else if (phase == 2) begin
                    if (m_pop) begin
                        void'(q.pop_front());
                        popped++;
                    end
                    if (e_iss) begin
                        q.push_back(cyc);
                        issued++;
                    end
                    if (popped == N) phase = 0;
                end
            end
        end
    end

    task automatic start_pulse();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    // mode 0: idx=i, x=i-32, y=-(i/2); mode 1: idx=i, random data, clip case at idx 5;
    // mode 2: random idx (duplicates) and data.
    task automatic write_ctu(input int mode, input int vld_pct);
        int n = 0;
        bit done = 0;
        for (int k = 0; k < 3000 && !done; k++) begin
            mv_vld_i  = ($urandom_range(0, 99) < vld_pct);
            out_rdy_i = 1'($urandom_range(0, 1));
            case (mode)
                0: begin
                    mv_idx_i = 6'(n); mv_x_i = 10'(n - 32); mv_y_i = 9'(-(n / 2));
                end
                1: begin
                    mv_idx_i = 6'(n); mv_x_i = 10'($urandom); mv_y_i = 9'($urandom);
                    if (n == 5) begin
                        mv_x_i = 10'(300); mv_y_i = 9'(-200);
                    end
                end
                default: begin
                    mv_idx_i = 6'($urandom); mv_x_i = 10'($urandom); mv_y_i = 9'($urandom);
                end
            endcase
            @(negedge clk);
            if (mv_vld_i) n++;
            done = wr_done_o;
            tick();
        end
        mv_vld_i = 1'b0;
        chk("wr_timeout", done, 1);
    endtask

    task automatic read_ctu(input int rdy_pct, input int mode, output int first_n,
                            output int done_n);
        int n = 0;
        bit done = 0, seen = 0;
        first_n = 0;
        done_n  = 0;
        for (int k = 0; k < 4000 && !done; k++) begin
            out_rdy_i = ($urandom_range(0, 99) < rdy_pct);
            mv_vld_i  = 1'($urandom_range(0, 1));
            mv_idx_i  = 6'($urandom);
            @(negedge clk);
            n++;
            if (out_vld_o && !seen) begin
                seen    = 1;
                first_n = n;
            end
            if (out_vld_o && out_rdy_i) begin
                if (mode == 0 && out_idx_o == 6'd0) chk("basic_word0", out_dat_o, 13'h0060);
                if (mode == 0 && out_idx_o == 6'd63) chk("basic_word63", out_dat_o, 13'h109F);
                if (mode == 1 && out_idx_o == 6'd5) chk("clip_idx5", out_dat_o, 13'h103F);
            end
            if (rd_done_o) begin
                done   = 1;
                done_n = n;
            end
            tick();
        end
        mv_vld_i  = 1'b0;
        out_rdy_i = 1'b0;
        chk("rd_timeout", done, 1);
    endtask

    initial begin
        int f, d, hs;
        bit seen;
        rst = 1'b1; start_i = 1'b0; mv_vld_i = 1'b0; out_rdy_i = 1'b0;
        mv_idx_i = '0; mv_x_i = '0; mv_y_i = '0;
        s_start = 1'b0; s_vld = 1'b0; s_out_rdy = 1'b0; s_idx = '0; s_x = '0; s_y = '0;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("init_busy", busy_o, 0);
        chk("init_rd_ena", ram_rd_ena_o, 1);
        chk("init_wr_ena", ram_wr_ena_o, 1);
        chk("init1_busy", s_busy, 0);
        tick();

        // NUM_MV=1: single write, single read, held output under stall.
        s_start = 1'b1; tick(); s_start = 1'b0;
        s_vld = 1'b1; s_idx = 6'd0; s_x = 10'(-100); s_y = 9'(50);
        @(negedge clk);
        chk("n1_wr_done", s_wr_done, 1);
        chk("n1_wr_ena", s_wr_ena, 0);
        chk("n1_wr_dat", s_wr_dat, 13'h0FC0);
        tick();
        s_vld = 1'b0;
        @(negedge clk);
        chk("n1_rd_issue", s_rd_ena, 0);
        chk("n1_rd_adr", s_adr, 0);
        tick();
        @(negedge clk);
        chk("n1_vld_lat", s_out_vld, 0);
        chk("n1_one_read", s_rd_ena, 1);
        tick();
        @(negedge clk);
        chk("n1_vld", s_out_vld, 1);
        chk("n1_dat", s_out_dat, 13'h0FC0);
        chk("n1_no_done", s_rd_done, 0);
        tick();
        @(negedge clk);
        chk("n1_hold_vld", s_out_vld, 1);
        chk("n1_hold_dat", s_out_dat, 13'h0FC0);
        tick();
        s_out_rdy = 1'b1;
        @(negedge clk);
        chk("n1_rd_done", s_rd_done, 1);
        chk("n1_idx", s_out_idx, 0);
        tick();
        @(negedge clk);
        chk("n1_idle", s_busy, 0);
        tick();
        // Overwrite index 0: the new CTU must stream the newer word.
        s_start = 1'b1; tick(); s_start = 1'b0;
        s_vld = 1'b1; s_x = 10'(20); s_y = 9'(-5);
        tick();
        s_vld = 1'b0;
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (s_out_vld) begin
                seen = 1;
                chk("n1_overwrite", s_out_dat, 13'h1D94);
            end
            tick();
        end
        chk("n1_ovr_timeout", seen, 1);
        s_out_rdy = 1'b0;

        // Basic CTU with full-rate output.
        start_pulse();
        write_ctu(0, 100);
        read_ctu(100, 0, f, d);
        chk("basic_first_lat", f, 3);
        chk("basic_done_at", d, 66);

        // Clipping.
        start_pulse();
        write_ctu(1, 100);
        read_ctu(100, 1, f, d);

        // Duplicate indices, gaps on input, backpressure on output.
        for (int r = 0; r < 3; r++) begin
            start_pulse();
            write_ctu(2, 70);
            read_ctu((r == 0) ? 30 : 60, 2, f, d);
        end

        // Abort during readout after 20 words.
        start_pulse();
        write_ctu(1, 100);
        hs = 0;
        for (int k = 0; k < 300 && hs < 20; k++) begin
            out_rdy_i = 1'b1;
            @(negedge clk);
            if (out_vld_o && out_rdy_i) hs++;
            tick();
        end
        chk("abort_reach20", hs, 20);
        start_i = 1'b1;
        @(negedge clk);
        tick();
        start_i = 1'b0;
        @(negedge clk);
        chk("abort_vld_off", out_vld_o, 0);
        chk("abort_state_wr", mv_rdy_o, 1);
        chk("abort_no_done", rd_done_o, 0);
        tick();
        write_ctu(2, 80);
        read_ctu(100, 2, f, d);

        // Reset in the middle of collection, with start_i asserted alongside.
        start_pulse();
        for (int i = 0; i < 30; i++) begin
            mv_vld_i = 1'b1; mv_idx_i = 6'(i); mv_x_i = 10'($urandom); mv_y_i = 9'($urandom);
            tick();
        end
        rst = 1'b1; start_i = 1'b1;
        tick();
        rst = 1'b0; start_i = 1'b0; mv_vld_i = 1'b0;
        @(negedge clk);
        chk("rstmid_rdy", mv_rdy_o, 0);
        chk("rstmid_busy", busy_o, 0);
        chk("rstmid_wr_done", wr_done_o, 0);
        chk("rstmid_vld", out_vld_o, 0);
        chk("rstmid_wr_ena", ram_wr_ena_o, 1);
        chk("rstmid_rd_ena", ram_rd_ena_o, 1);
        tick();
        start_pulse();
        write_ctu(2, 60);
        read_ctu(50, 2, f, d);

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ime_mv_buf_ctrl.md
IME_MV_BUF_CTRL -- requirements
Module: ime_mv_buf_ctrl

Interface
REQ-001 SHALL have parameter NUM_MV, default 64, MVs per CTU; legal range 1..64.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port start_i  in  1  one-cycle pulse, begin a new CTU (aborts any operation in progress).
REQ-005 SHALL have ports mv_vld_i in 1, mv_rdy_o out 1  IME result handshake.
REQ-006 SHALL have ports mv_idx_i in 6 (8x8 block index), mv_x_i in 10 (signed), mv_y_i in 9 (signed).
REQ-007 SHALL have port wr_done_o  out  1  pulse, all NUM_MV MVs written.
REQ-008 SHALL have ports out_vld_o out 1, out_rdy_i in 1, out_idx_o out 6, out_dat_o out 13  MV stream to FME.
REQ-009 SHALL have port rd_done_o  out  1  pulse, last MV handed to FME.
REQ-010 SHALL have ports ram_adr_o out 6, ram_wr_ena_o out 1 (low active), ram_wr_dat_o out 13, ram_rd_ena_o out 1 (low active), ram_rd_dat_i in 13  to the 64x13 single-port MV RAM.
REQ-011 SHALL have port busy_o  out  1  high in states WR and RD.

Function
REQ-012 SHALL implement FSM states IDLE, WR, RD.
- IDLE->WR on start_i.
- WR->RD on the cycle after the NUM_MV-th write handshake.
- RD->IDLE on the cycle after the NUM_MV-th output handshake.
- Any state->WR on start_i.
REQ-013 SHALL drive mv_rdy_o = 1 only in state WR; accept = mv_vld_i & mv_rdy_o & !start_i.
REQ-014 SHALL clip mv_x_i to [-64,63] and mv_y_i to [-32,31], then pack ram_wr_dat_o = {mv_y[5:0], mv_x[6:0]} (two's complement).
REQ-015 SHALL drive the RAM write combinationally on accept: ram_wr_ena_o=0, ram_adr_o=mv_idx_i; writes to a repeated index overwrite the earlier value and still count.
REQ-016 SHALL pulse wr_done_o for one cycle on the cycle of the NUM_MV-th accept.
REQ-017 SHALL in RD issue reads at addresses 0..NUM_MV-1 in ascending order: ram_rd_ena_o=0, ram_adr_o=rd_cnt. The RAM is never read and written in the same cycle.
REQ-018 SHALL capture ram_rd_dat_i on the cycle after the read issue into a 2-entry output FIFO together with its index.
REQ-019 SHALL issue a read only when (fifo_occupancy + reads_in_flight - pop_this_cycle) < 2. This sustains 1 MV/cycle when out_rdy_i=1 and never overflows the FIFO.
REQ-020 SHALL present the FIFO head on out_dat_o/out_idx_o with out_vld_o=1 and hold it stable until out_vld_o & out_rdy_i.
REQ-021 SHALL pulse rd_done_o for one cycle on the NUM_MV-th output handshake.
REQ-022 SHALL on start_i in WR or RD:
- clear the counters;
- flush the FIFO;
- discard any in-flight RAM read data;
- suppress that cycle's write and read enables.
REQ-023 SHALL ignore out_rdy_i outside RD and ignore mv_vld_i outside WR.
REQ-024 SHALL have a first-word latency of 2 cycles: RD entry -> read issue -> out_vld_o.

Reset
REQ-025 SHALL on rst=1 enter IDLE and clear the counters, FIFO and in-flight flag, with outputs:
- mv_rdy_o, wr_done_o, out_vld_o, rd_done_o, busy_o = 0;
- ram_wr_ena_o = 1, ram_rd_ena_o = 1;
- ram_adr_o, ram_wr_dat_o, out_dat_o, out_idx_o = 0.
REQ-026 SHALL give rst priority over start_i and all handshakes; rst mid-WR or mid-RD discards the CTU without a done pulse.

Verification
REQ-027 Basic: start, 64 MVs idx=i, x=i-32, y=-(i/2), out_rdy_i=1 -> wr_done_o at 64th accept; out_dat_o in order 0..63 at one per cycle; rd_done_o once.
REQ-028 Clipping: mv_x_i=300, mv_y_i=-200 at idx 5 -> word {6'b100000, 7'b0111111} = 13'h103F read back at out_idx_o=5.
REQ-029 Backpressure: random out_rdy_i 30% -> no lost or duplicated word; out_dat_o stable while stalled; RAM read never issued with FIFO+inflight=2 and no pop.
REQ-030 Abort: start_i at read 20 of 64 -> FIFO flushed, out_vld_o=0 next cycle, state WR, no rd_done_o; a fresh CTU then completes correctly.
REQ-031 Reset mid-op: rst for 1 cycle during WR (30 accepted) -> all outputs at REQ-025 values next cycle; start accepted after rst releases.
REQ-032 NUM_MV=1 and duplicate-index writes -> single-entry streaming and last-write-wins value.
